// File: rtl/obi_wb_bridge.sv
// Bridge from a core's req/gnt/rvalid memory port to a single-master Wishbone bus.
// Accepted requests are queued in a small FIFO and answered strictly in order.
module obi_wb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 2,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   // core side
   input  logic                      req_i,
   output logic                      gnt_o,
   input  logic [ADDR_WIDTH-1:0]     addr_i,
   input  logic                      we_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   output logic                      rvalid_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      err_o,
   // Wishbone side
   output logic                      cyc_o,
   output logic                      stb_o,
   output logic                      we_o,
   output logic [DATA_WIDTH/8-1:0]   sel_o,
   output logic [ADDR_WIDTH-1:0]     addr_o,
   output logic [DATA_WIDTH-1:0]     data_o,
   input  logic [DATA_WIDTH-1:0]     data_i,
   input  logic                      ack_i,
   input  logic                      err_i,
   output logic                      busy_o
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W    = $clog2(DEPTH + 1);
   localparam int TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUS  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [ADDR_WIDTH-1:0] r_addr_mem  [DEPTH];
   logic                  r_we_mem    [DEPTH];
   logic [BE_WIDTH-1:0]   r_be_mem    [DEPTH];
   logic [DATA_WIDTH-1:0] r_wdata_mem [DEPTH];

   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  r_rvalid;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_bus;
   logic                  w_push;
   logic                  w_end;
   logic                  w_timeout;
   logic                  w_resp_err;
   logic                  w_head_we;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // No bypass: a slot freed by this cycle's pop is only usable next cycle.
   assign gnt_o     = rst_n & req_i & (r_count < CNT_W'(DEPTH));
   assign w_push    = req_i & gnt_o;
   assign w_bus     = (r_state == S_BUS);
   assign w_head_we = r_we_mem[r_rd_ptr];

   assign w_end      = w_bus & (ack_i | err_i | w_timeout);
   assign w_resp_err = err_i | (~ack_i & w_timeout);

   // Request storage; contents need no reset since count/pointers gate them.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr_mem[r_wr_ptr]  <= addr_i;
         r_we_mem[r_wr_ptr]    <= we_i;
         r_be_mem[r_wr_ptr]    <= be_i;
         r_wdata_mem[r_wr_ptr] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_end) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_end})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_push || (r_count != '0)) begin
               w_state_next = S_BUS;
            end
         end
         S_BUS: begin
            // Stay on the bus if anything remains after the pop, including a same-cycle push.
            if (w_end && !((r_count > CNT_W'(1)) || w_push)) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         logic [TO_W-1:0] r_tcnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_tcnt <= '0;
            end else if (!w_bus || w_end) begin
               r_tcnt <= '0;
            end else if (r_tcnt != TO_W'(TIMEOUT_CYCLES)) begin
               r_tcnt <= r_tcnt + 1'b1;
            end
         end

         assign w_timeout = w_bus & (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else if (w_end) begin
         r_rvalid <= 1'b1;
         r_err    <= w_resp_err;
         r_rdata  <= (!w_resp_err && !w_head_we) ? data_i : '0;
      end else begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end
   end

   assign cyc_o  = w_bus;
   assign stb_o  = w_bus;
   assign we_o   = w_bus & w_head_we;
   assign sel_o  = w_bus ? r_be_mem[r_rd_ptr]    : '0;
   assign addr_o = w_bus ? r_addr_mem[r_rd_ptr]  : '0;
   assign data_o = w_bus ? r_wdata_mem[r_rd_ptr] : '0;

   assign rvalid_o = r_rvalid;
   assign err_o    = r_err;
   assign rdata_o  = r_rdata;
   assign busy_o   = w_bus | (r_count != '0);

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Randomised scoreboard bench for obi_wb_bridge: a behavioural slave decides each
// transaction's outcome, pushes the expected response, and a monitor checks rvalid.
module tb_obi_wb_bridge;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 4;
   localparam int TO    = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_i = 1'b0;
   logic          gnt_o;
   logic [AW-1:0] addr_i = '0;
   logic          we_i = 1'b0;
   logic [BW-1:0] be_i = '0;
   logic [DW-1:0] wdata_i = '0;
   logic          rvalid_o;
   logic [DW-1:0] rdata_o;
   logic          err_o;
   logic          cyc_o;
   logic          stb_o;
   logic          we_o;
   logic [BW-1:0] sel_o;
   logic [AW-1:0] addr_o;
   logic [DW-1:0] data_o;
   logic [DW-1:0] data_i = '0;
   logic          ack_i = 1'b0;
   logic          err_i = 1'b0;
   logic          busy_o;

   obi_wb_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
      .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .addr_o(addr_o),
      .data_o(data_o), .data_i(data_i), .ack_i(ack_i), .err_i(err_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc_num = 0;
   always @(posedge clk) cyc_num <= cyc_num + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [BW-1:0] be;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int unsigned   due;
   } rsp_t;

   req_t wbq[$];      // accepted, not yet on the bus
   rsp_t rspq[$];     // expected responses, oldest first
   req_t cur;
   bit   in_txn = 0;
   int   k = 0;
   int   wait_n = 0;
   int   kind = 0;    // 0 ack, 1 err, 2 ack+err, 3 never (timeout)
   int   force_kind = -1;
   bit   use_fixed = 0;
   req_t fixed_req;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_rsp = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_num);
   endtask

   task automatic push_rsp(input logic [DW-1:0] rd, input logic e);
      rsp_t r;
      r.rdata = rd;
      r.err   = e;
      r.due   = cyc_num + 1;
      rspq.push_back(r);
   endtask

   // One clock cycle: check bus state, play the slave, offer a request.
   task automatic step(input int req_pct);
      bit   exp_cyc;
      int   cnt;
      req_t r;
      @(negedge clk);
      exp_cyc = in_txn || (wbq.size() > 0);
      chk("cyc_o", cyc_o, exp_cyc);
      chk("stb_o", stb_o, exp_cyc);
      chk("busy_o", busy_o, exp_cyc);
      ack_i  = 1'b0;
      err_i  = 1'b0;
      data_i = $urandom;
      if (exp_cyc && cyc_o) begin
         if (!in_txn) begin
            cur    = wbq.pop_front();
            in_txn = 1;
            k      = 0;
            chk("addr_o", addr_o, cur.addr);
            chk("we_o", we_o, cur.we);
            chk("sel_o", sel_o, cur.be);
            chk("data_o", data_o, cur.wdata);
            if (force_kind >= 0) begin
               kind   = force_kind;
               wait_n = 0;
            end else begin
               kind   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
               wait_n = $urandom_range(0, 3);
            end
         end
         cnt = wbq.size() + 1;
         if (force_kind == 0) data_i = 32'hDEADBEEF;
         if (kind == 3) begin
            if (k == TO - 1) begin
               push_rsp('0, 1'b1);
               in_txn = 0;
            end
         end else if (k == wait_n) begin
            ack_i = (kind != 1);
            err_i = (kind != 0);
            push_rsp((kind == 0 && !cur.we) ? data_i : '0, kind != 0);
            in_txn = 0;
         end
         k++;
      end else begin
         cnt = wbq.size() + int'(in_txn);
         if (!exp_cyc) begin
            ack_i = ($urandom_range(0, 3) == 0);
            err_i = ($urandom_range(0, 3) == 0);
         end
      end
      if (use_fixed) begin
         req_i = 1'b1;
         r     = fixed_req;
      end else begin
         req_i   = ($urandom_range(0, 99) < req_pct);
         r.addr  = $urandom & 32'hFFFF_FFFC;
         r.we    = $urandom_range(0, 1);
         r.be    = $urandom_range(0, 15);
         r.wdata = $urandom;
      end
      addr_i  = r.addr;
      we_i    = r.we;
      be_i    = r.be;
      wdata_i = r.wdata;
      #1;
      chk("gnt_o", gnt_o, req_i && (cnt < DEPTH));
      if (req_i && gnt_o) begin
         wbq.push_back(r);
         use_fixed = 0;
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_gnt"}, gnt_o, 1'b0);
      chk({tag, "_cyc"}, cyc_o, 1'b0);
      chk({tag, "_stb"}, stb_o, 1'b0);
      chk({tag, "_rvalid"}, rvalid_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_addr"}, addr_o, '0);
      chk({tag, "_sel_we"}, {sel_o, we_o, err_o}, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && (wbq.size() > 0 || in_txn || rspq.size() > 0); i++) step(0);
      chk("drained", wbq.size() + int'(in_txn) + rspq.size(), 0);
   endtask

   // Response monitor: pops the scoreboard whenever the bridge returns a response.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rvalid_o) begin
            n_rsp++;
            if (rspq.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_rvalid: got rdata %0h err %0b expected no response", rdata_o, err_o);
            end else begin
               e = rspq.pop_front();
               $display("rsp %0d: rdata=%08h err=%0b cycle=%0d", n_rsp, rdata_o, err_o, cyc_num);
               chk("rdata_o", rdata_o, e.rdata);
               chk("err_o", err_o, e.err);
               chk("rsp_cycle", cyc_num, e.due);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      req_i = 1'b1;
      #1;
      check_outputs_zero("reset");
      req_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single read at 0x100, immediate ack.
      force_kind = 0;
      fixed_req.addr = 32'h100; fixed_req.we = 1'b0; fixed_req.be = 4'hF; fixed_req.wdata = '0;
      use_fixed = 1;
      step(0);
      repeat (4) step(0);
      force_kind = -1;

      // Random traffic: heavy then light.
      repeat (400) step(75);
      repeat (300) step(30);
      drain();

      // Reset while a transaction is in flight with two more queued.
      force_kind = 3;
      repeat (3) step(100);
      @(negedge clk);
      req_i = 1'b1;
      ack_i = 1'b0;
      err_i = 1'b0;
      chk("pre_reset_busy", busy_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      wbq.delete();
      rspq.delete();
      in_txn = 0;
      req_i  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      force_kind = 0;
      fixed_req.addr = 32'h200;
      use_fixed = 1;
      step(0);
      force_kind = -1;
      drain();
      repeat (100) step(60);
      drain();
      repeat (2) step(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
